// File: rtl/echo_pkg.sv
// Shared types and defaults for the ultrasonic echo capture block.
package echo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_TRIG_CYCLES    = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 3800000;
    localparam int DEF_CNT_W          = 22;
    localparam int FILTER_DEPTH       = 4;
    localparam int SYNC_STAGES        = 2;

endpackage

// File: rtl/echo_sync.sv
// Echo input synchronizer with optional glitch filter (enabled by ECHO_FILTER_EN).
module echo_sync
    import echo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic echo_in,
    output logic echo_s
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = echo_in;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

`ifdef ECHO_FILTER_EN
    localparam int RUN_W = $clog2(FILTER_DEPTH);

    logic             filt_reg;
    logic [RUN_W-1:0] run_reg;

    // run_reg counts consecutive cycles the synchronized level disagrees with the output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_reg <= 1'b0;
            run_reg  <= '0;
        end else if (sync_reg[SYNC_STAGES-1] == filt_reg) begin
            run_reg <= '0;
        end else if (run_reg == RUN_W'(FILTER_DEPTH - 1)) begin
            filt_reg <= sync_reg[SYNC_STAGES-1];
            run_reg  <= '0;
        end else begin
            run_reg <= run_reg + 1'b1;
        end
    end

    assign echo_s = filt_reg;
`else
    assign echo_s = sync_reg[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/echo_capture.sv
// Ultrasonic ranging controller: trigger pulse on each tick rising edge, then echo width measurement.
// Optional glitch filter on the echo path is enabled with ECHO_FILTER_EN.
module echo_capture
    import echo_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             echo_in,
    output logic             trig_out,
    output logic [CNT_W-1:0] echo_cnt,
    output logic             cnt_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] echo_cnt_reg;
    logic             tick_q_reg;
    logic             echo_q_reg;
    logic             trig_reg;
    logic             cnt_valid_reg;
    logic             timeout_reg;
    logic             echo_s;
    logic             start;
    logic             echo_rise;

    echo_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .echo_in (echo_in),
        .echo_s  (echo_s)
    );

    assign start     = tick_in & ~tick_q_reg & (state_reg == IDLE);
    assign echo_rise = echo_s & ~echo_q_reg;

    // Result registers load on the transition into DONE so the strobe lands in the DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            echo_cnt_reg  <= '0;
            tick_q_reg    <= 1'b0;
            echo_q_reg    <= 1'b0;
            trig_reg      <= 1'b0;
            cnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            tick_q_reg    <= tick_in;
            echo_q_reg    <= echo_s;
            cnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= TRIG;
                        cnt_reg   <= '0;
                        trig_reg  <= 1'b1;
                    end
                end
                TRIG: begin
                    if (cnt_reg == TRIG_LAST) begin
                        state_reg <= WAIT_ECHO;
                        cnt_reg   <= '0;
                        trig_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    // Timeout is checked first so it wins over a coincident echo edge
                    if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg     <= DONE;
                        echo_cnt_reg  <= TIMEOUT_VAL;
                        cnt_valid_reg <= 1'b1;
                        timeout_reg   <= 1'b1;
                    end else if (echo_rise) begin
                        state_reg <= MEASURE;
                        cnt_reg   <= CNT_W'(1);
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        state_reg     <= DONE;
                        echo_cnt_reg  <= cnt_reg;
                        cnt_valid_reg <= 1'b1;
                    end else if (cnt_reg >= TIMEOUT_VAL) begin
                        state_reg <= DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!echo_s) begin
                        state_reg     <= DONE;
                        echo_cnt_reg  <= TIMEOUT_VAL;
                        cnt_valid_reg <= 1'b1;
                        timeout_reg   <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    trig_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign trig_out  = trig_reg;
    assign echo_cnt  = echo_cnt_reg;
    assign cnt_valid = cnt_valid_reg;
    assign timeout   = timeout_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_echo_capture.sv
// Self-checking bench for echo_capture with randomized ranging cycles against a width-based model.
module tb_echo_capture;

    localparam int TRIG = 10;
    localparam int TO   = 200;
    localparam int W    = 22;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick_in = 1'b0;
    logic         echo_in = 1'b0;
    logic         trig_out;
    logic [W-1:0] echo_cnt;
    logic         cnt_valid;
    logic         timeout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    int           valid_pulses = 0;
    int           valid_hi = 0;
    int           trig_rises = 0;
    int           stray_to = 0;
    logic [W-1:0] cap_cnt = '0;
    logic         cap_to = 1'b0;
    logic         valid_prev = 1'b0;
    logic         trig_prev = 1'b0;

    echo_capture #(
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .echo_in   (echo_in),
        .trig_out  (trig_out),
        .echo_cnt  (echo_cnt),
        .cnt_valid (cnt_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Observe strobes and trigger edges between active edges
    always @(negedge clk) begin
        if (cnt_valid === 1'b1) begin
            valid_hi++;
            cap_cnt = echo_cnt;
            cap_to  = timeout;
        end
        if (cnt_valid === 1'b1 && valid_prev !== 1'b1) valid_pulses++;
        if (timeout === 1'b1 && cnt_valid !== 1'b1) stray_to++;
        if (trig_out === 1'b1 && trig_prev !== 1'b1) trig_rises++;
        valid_prev = cnt_valid;
        trig_prev  = trig_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Width of echo_s as seen after the synchronizer: filtered pulses of 3 cycles or less vanish
    function automatic int eff_width(input int w);
`ifdef ECHO_FILTER_EN
        return (w < 4) ? 0 : w;
`else
        return w;
`endif
    endfunction

    function automatic int exp_cnt(input int w);
        int e;
        e = eff_width(w);
        if (e == 0 || e > TO) return TO;
        return e;
    endfunction

    function automatic bit exp_to(input int w);
        int e;
        e = eff_width(w);
        return (e == 0 || e > TO);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b expected 0", trig_out); end
        checks++; if (echo_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", echo_cnt); end
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        $display("reset: outputs idle");
    endtask

    // One ranging cycle: optional echo already high during trigger, gap, echo pulse, optional tick mid-measure
    task automatic ranging(input string name, input int pre_hi, input int delay, input int width,
                           input bit tick_mid);
        int v0, r0, h0, n;
        v0 = valid_pulses;
        r0 = trig_rises;
        h0 = valid_hi;

        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL %s trig_idle: got %b expected 0", name, trig_out); end
        tick_in = 1'b1;
        step();
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL %s trig_rise: got %b expected 1", name, trig_out); end
        if (pre_hi > 0) echo_in = 1'b1;
        n = 0;
        while (trig_out === 1'b1 && n < 100) begin
            n++;
            if (n == 3) tick_in = 1'b0;
            step();
        end
        tick_in = 1'b0;
        checks++; if (n != TRIG) begin errors++; $display("FAIL %s trig_width: got %0d expected %0d", name, n, TRIG); end

        if (pre_hi > 0) begin
            repeat (pre_hi) step();
            echo_in = 1'b0;
        end
        repeat (delay) step();
        if (width > 0) begin
            echo_in = 1'b1;
            for (int i = 0; i < width; i++) begin
                step();
                if (tick_mid && i == 5) tick_in = 1'b1;
                if (tick_mid && i == 10) tick_in = 1'b0;
            end
            if (width > TO) begin
                checks++;
                if (valid_pulses != v0) begin
                    errors++;
                    $display("FAIL %s strobe_before_fall: got %0d strobes expected 0", name, valid_pulses - v0);
                end
            end
            echo_in = 1'b0;
        end

        n = 0;
        while (valid_pulses == v0 && n < 1000) begin
            step();
            n++;
        end
        checks++; if (valid_pulses != v0 + 1) begin errors++; $display("FAIL %s strobe_seen: got %0d expected 1", name, valid_pulses - v0); end
        checks++; if (cap_cnt !== W'(exp_cnt(width))) begin errors++; $display("FAIL %s echo_cnt: got %0d expected %0d", name, cap_cnt, exp_cnt(width)); end
        checks++; if (cap_to !== exp_to(width)) begin errors++; $display("FAIL %s timeout: got %b expected %b", name, cap_to, exp_to(width)); end

        repeat (20) step();
        checks++; if (valid_hi - h0 != 1) begin errors++; $display("FAIL %s strobe_width: got %0d expected 1", name, valid_hi - h0); end
        checks++; if (trig_rises - r0 != 1) begin errors++; $display("FAIL %s trig_count: got %0d expected 1", name, trig_rises - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after: got %b expected 0", name, busy); end
        checks++; if (echo_cnt !== W'(exp_cnt(width))) begin errors++; $display("FAIL %s cnt_hold: got %0d expected %0d", name, echo_cnt, exp_cnt(width)); end
        $display("ranging %s: pre=%0d delay=%0d width=%0d echo_cnt=%0d timeout=%0b", name, pre_hi, delay, width, cap_cnt, cap_to);
    endtask

    task automatic test_basic();
        ranging("basic57", 0, 30, 57, 1'b0);
    endtask

    task automatic test_no_echo();
        ranging("no_echo", 0, 0, 0, 1'b0);
    endtask

    task automatic test_long_echo();
        ranging("long500", 0, 20, 500, 1'b0);
    endtask

    task automatic test_tick_during_measure();
        ranging("tick_drop", 0, 15, 57, 1'b1);
        ranging("tick_next", 0, 12, 33, 1'b0);
    endtask

    task automatic test_pre_high();
        ranging("pre_high", 20, 15, 44, 1'b0);
    endtask

    task automatic test_glitch();
        ranging("glitch2", 0, 25, 2, 1'b0);
    endtask

    task automatic test_random();
        int d, w;
        for (int k = 0; k < 6; k++) begin
            d = int'($urandom_range(5, 150));
            w = int'($urandom_range(1, 260));
            ranging($sformatf("rand%0d", k), 0, d, w, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int v0, n;
        v0 = valid_pulses;
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        n = 0;
        while (trig_out === 1'b1 && n < 100) begin
            n++;
            step();
        end
        repeat (10) step();
        echo_in = 1'b1;
        repeat (20) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy_before: got %b expected 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL rst_mid trig: got %b expected 0", trig_out); end
        checks++; if (echo_cnt !== '0) begin errors++; $display("FAIL rst_mid cnt: got %0d expected 0", echo_cnt); end
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL rst_mid valid: got %b expected 0", cnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_mid timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        echo_in = 1'b0;
        repeat (50) step();
        checks++; if (valid_pulses != v0) begin errors++; $display("FAIL rst_mid discarded: got %0d strobes expected 0", valid_pulses - v0); end
        $display("reset mid-measure: outputs cleared, measurement discarded");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_echo();
        test_long_echo();
        test_tick_during_measure();
        test_pre_high();
        test_glitch();
        test_random();
        test_reset_mid();
        checks++;
        if (stray_to != 0) begin
            errors++;
            $display("FAIL stray_timeout: got %0d cycles expected 0", stray_to);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
